ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Multiplexed seven-segment display driver for the Nexys4DDR 8-digit display: the consumer side of the BCD digit counters produced by the reaction-timer FSM. Accepts four BCD digits through a valid/ready load handshake. Double-buffers them so updates land only on frame boundaries. Time-multiplexes the digits onto the active-low anode and cathode pins, with optional leading-zero blanking and whole-display blinking.

## Interface
Parameters:
- REFRESH_DIV, 100_000: clk cycles per digit slot (1 kHz at 100 MHz); minimum 2
- BLINK_TICKS, 250: refresh ticks per blink half-period (2 Hz toggle at defaults); minimum 1

Ports. One clock; reset is synchronous and active-high.
- clk, input, 1: system clock
- reset, input, 1: synchronous, active-high
- load_valid, input, 1: digits/dp_mask valid this cycle
- load_ready, output, 1: driver can accept a load
- digits, input, 16: {d3,d2,d1,d0} BCD; d3 = most significant, d0 = rightmost
- dp_mask, input, 4: decimal point per digit, 1 = lit
- blank_lz, input, 1: enable leading-zero blanking (level, sampled live)
- blink_en, input, 1: enable blinking (level, sampled live)
- ssdCathode, output, 7: {g,f,e,d,c,b,a}, active low
- ssdDp, output, 1: decimal point, active low
- ssdAnode, output, 8: active low; bits 7:4 are permanently 1

## Operation
- Load handshake:
  - A transfer occurs when load_valid && load_ready.
  - digits/dp_mask go to the pending register and pending is set.
  - load_ready = !pending.
- Frame boundary:
  - Occurs on the refresh tick that advances scan_idx from 3 to 0.
  - If pending is set, the pending register is copied to the display register and pending is cleared.
  - load_ready rises the next cycle.
  - load_valid is ignored while load_ready is low, including on the boundary cycle itself.
- Scan:
  - scan_idx cycles 0→1→2→3→0 on each refresh tick.
  - Anode bit scan_idx is driven 0 and all others 1.
- Segment decode:
  - Nibbles 0–9 map to standard glyphs; '0' = 7'b1000000, '8' = 7'b0000000.
  - Nibbles 10–15 show dash = 7'b0111111.
- Leading-zero blanking (blank_lz=1):
  - d3 is blank if d3==0.
  - d2 is blank if d3==0 && d2==0.
  - d1 is blank if d3, d2 and d1 are all 0.
  - d0 is never blanked.
  - A blanked digit drives cathode 7'b1111111 and its dp still follows dp_mask; the anode is still asserted.
- Blink (blink_en=1):
  - blink_phase toggles every BLINK_TICKS refresh ticks.
  - When blink_phase=1, all anodes are driven 1.
  - When blink_en=0, blink_phase is forced to 0 and the blink counter is cleared.

## Timing
- Reset values:
  - ssdAnode=8'hFF, ssdCathode=7'h7F, ssdDp=1, load_ready=1.
  - pending=0, display register=0, scan_idx=0, prescaler=0, blink_phase=0.
- Refresh tick:
  - Asserted one cycle when prescaler==REFRESH_DIV-1; prescaler then wraps to 0.
  - First tick occurs REFRESH_DIV cycles after reset deasserts.
- Outputs are registered and update the cycle after a tick.
- Anodes remain all-off from reset until the first tick. The first tick lights digit 0.
- Load-to-display latency: from 1 up to 4·REFRESH_DIV cycles, depending on when the next frame boundary occurs.
- A new glyph is never shown mid-frame; no tearing.
- Reset asserted mid-operation:
  - Returns every register to its reset value on the next edge.
  - Discards any pending load.

## Structure
- Shared package ssd_pkg holds:
  - SEG_BLANK, SEG_DASH and glyph constants
  - the function bcd_to_seg(nibble) → logic [6:0]
  - localparam NUM_DIGITS = 4
- Sub-module tick_gen(clk, reset, tick) with parameter DIV is the refresh prescaler; it is reusable by other display blocks.
- The remainder (handshake, buffers, scan, blink) is the top level of ssd_scan_driver.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_TICKS=2.
1. Reset, then load 16'h1234 with dp_mask=0:
   - Anodes cycle FE, FD, FB, F7.
   - Cathodes show 4, 3, 2, 1 (d0 first).
   - ssdDp=1 throughout.
2. Load 16'h0007 with blank_lz=1:
   - Digits 3, 2 and 1 show 7F with their anodes still asserted.
   - Digit 0 shows '7' (7'b1111000).
3. Hold load_valid with 16'h5555 starting mid-frame:
   - load_ready falls the cycle after acceptance.
   - Display keeps the old value until the boundary; the new value appears from the next digit-0 slot.
   - load_ready=1 the cycle after the boundary.
4. Assert blink_en:
   - All anodes FF for 2 ticks, then scanning for 2 ticks, repeating.
   - Deasserting blink_en restores scanning on the next tick.
5. Load 16'hABCF:
   - Every digit shows dash 7'b0111111.
6. Assert reset mid-frame with a pending load:
   - Next cycle: anodes FF, load_ready=1.
   - After reset, display register = 0; pending data is never shown.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display blocks: glyph constants,
// the load bundle type and the BCD-to-segment decoder. Segments are
// ordered {g,f,e,d,c,b,a} and are active low.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // One complete display image: four BCD nibbles plus their decimal points.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;

    // Non-BCD nibbles render as a dash so bad data is visible, not hidden.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every DIV clock cycles.
// The first tick appears DIV cycles after reset is released.
module tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;

    // Count 0..DIV-1 and wrap; the tick is the terminal count itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed four-digit seven-segment driver. Loads arrive through a
// valid/ready handshake into a pending buffer and are promoted to the
// display buffer only when the scan wraps from digit 3 to digit 0, so a
// frame is always drawn from a single image. All pin outputs are registered
// and change only on refresh ticks.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              ssdCathode,
    output logic                    ssdDp,
    output logic [7:0]              ssdAnode
);

    localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_TICKS - 1);
    localparam logic [1:0] LAST_SLOT = 2'(NUM_DIGITS - 1);

    logic tick;

    logic           pending_q, pending_d;
    frame_t         pend_q, pend_d;
    frame_t         disp_q, disp_d;
    logic [1:0]     scan_idx_q, scan_idx_d;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_phase_q, blink_phase_d;
    logic [3:0]     anode_q, anode_d;
    logic [6:0]     cathode_q, cathode_d;
    logic           dp_q, dp_d;

    logic [3:0]     cur_nibble;
    logic           lz_blank;
    logic [6:0]     cur_seg;

    tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign load_ready = !pending_q;

    // Glyph for the digit under the scan pointer. A digit is a leading zero
    // when it and every more significant digit are zero; digit 0 never is.
    always_comb begin
        cur_nibble = disp_q.digits[{scan_idx_q, 2'b00} +: 4];
        lz_blank   = blank_lz && (scan_idx_q != 2'd0)
                     && ((disp_q.digits >> {scan_idx_q, 2'b00}) == '0);
        cur_seg    = lz_blank ? SEG_BLANK : bcd_to_seg(cur_nibble);
    end

    // Next-state logic: handshake, frame-boundary promotion, scan and blink.
    always_comb begin
        pending_d     = pending_q;
        pend_d        = pend_q;
        disp_d        = disp_q;
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        anode_d       = anode_q;
        cathode_d     = cathode_q;
        dp_d          = dp_q;

        if (tick) begin
            anode_d    = (blink_en && blink_phase_q) ? 4'hF
                                                     : ~(4'b0001 << scan_idx_q);
            cathode_d  = cur_seg;
            dp_d       = ~disp_q.dp[scan_idx_q];
            scan_idx_d = scan_idx_q + 2'd1;

            if ((scan_idx_q == LAST_SLOT) && pending_q) begin
                disp_d    = pend_q;
                pending_d = 1'b0;
            end

            if (blink_en) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BCW'(1);
                end
            end
        end

        if (!blink_en) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end

        if (load_valid && load_ready) begin
            pend_d.digits = digits;
            pend_d.dp     = dp_mask;
            pending_d     = 1'b1;
        end
    end

    // State and output registers; reset leaves the display dark and empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q     <= 1'b0;
            pend_q        <= '0;
            disp_q        <= '0;
            scan_idx_q    <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            anode_q       <= 4'hF;
            cathode_q     <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            pending_q     <= pending_d;
            pend_q        <= pend_d;
            disp_q        <= disp_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            dp_q          <= dp_d;
        end
    end

    assign ssdAnode   = {4'hF, anode_q};
    assign ssdCathode = cathode_q;
    assign ssdDp      = dp_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver with a small refresh divider. A reference model
// predicts every pin each cycle from the display rules (tick count, slot
// number, frame swap on wrap), and a few directed scenarios add spot checks.
module tb_ssd_scan_driver;

    localparam int RDIV = 4;
    localparam int BT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [6:0]  ssdCathode;
    logic        ssdDp;
    logic [7:0]  ssdAnode;

    int errorCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .REFRESH_DIV (RDIV),
        .BLINK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .ssdCathode (ssdCathode),
        .ssdDp      (ssdDp),
        .ssdAnode   (ssdAnode)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference glyph table for active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Model state: cycle count since reset, tick count, blink tick count.
    int          n, tickCount, blinkK, slot;
    logic        mPend, readyNow, blankIt, blinkOff;
    logic [15:0] mPendDig, mDispDig, upper;
    logic [3:0]  mPendDp, mDispDp;
    logic [7:0]  expAnode;
    logic [6:0]  expCath;
    logic        expDp;
    bit          modelLive = 1'b0;

    // Reference model, evaluated at each rising edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            modelLive = 1'b1;
            if (reset) begin
                n = 0; tickCount = 0; blinkK = 0;
                mPend = 1'b0; mPendDig = '0; mPendDp = '0;
                mDispDig = '0; mDispDp = '0;
                expAnode = 8'hFF; expCath = 7'h7F; expDp = 1'b1;
            end else begin
                readyNow = !mPend;
                if ((n % RDIV) == RDIV - 1) begin
                    slot     = tickCount % 4;
                    upper    = mDispDig >> (4 * slot);
                    blankIt  = blank_lz && (slot != 0) && (upper == 16'h0);
                    expCath  = blankIt ? 7'h7F : glyph(upper[3:0]);
                    expDp    = ~mDispDp[slot];
                    blinkOff = blink_en && (((blinkK / BT) % 2) == 1);
                    expAnode = blinkOff ? 8'hFF : ~(8'd1 << slot);
                    if (blink_en) blinkK++;
                    tickCount++;
                    if (slot == 3 && mPend) begin
                        mDispDig = mPendDig;
                        mDispDp  = mPendDp;
                        mPend    = 1'b0;
                    end
                end
                n++;
                if (!blink_en) blinkK = 0;
                if (load_valid && readyNow) begin
                    mPendDig = digits;
                    mPendDp  = dp_mask;
                    mPend    = 1'b1;
                end
            end
        end
    end

    // Compare every pin against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (modelLive) begin
                checkOutput("anode", 16'(ssdAnode), 16'(expAnode));
                checkOutput("cathode", 16'(ssdCathode), 16'(expCath));
                checkOutput("dp", 16'(ssdDp), 16'(expDp));
                checkOutput("ready", 16'(load_ready), 16'(!mPend));
            end
        end
    end

    task automatic runCycles(input int count);
        repeat (count) @(negedge clk);
    endtask

    // Wait (bounded) for ready, then offer one word for a single cycle.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp);
        int waited = 0;
        while (load_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) checkOutput("ready_timeout", 16'h0, 16'h1);
        digits     = d;
        dp_mask    = dp;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    bit sawOff;

    initial begin
        reset = 1'b1;
        runCycles(3);
        checkOutput("rst_anode", 16'(ssdAnode), 16'h00FF);
        checkOutput("rst_cath", 16'(ssdCathode), 16'h007F);
        checkOutput("rst_dp", 16'(ssdDp), 16'h0001);
        checkOutput("rst_ready", 16'(load_ready), 16'h0001);
        reset = 1'b0;

        // Plain digits, scanned right to left.
        applyStimulus(16'h1234, 4'h0);
        runCycles(40);

        // Leading zeros blanked, only the units digit lit.
        blank_lz = 1'b1;
        applyStimulus(16'h0007, 4'h0);
        runCycles(36);
        for (int i = 0; i < 16; i++) begin
            checkOutput("lz_glyph", 16'(ssdCathode == 7'h7F || ssdCathode == 7'h78), 16'h1);
            @(negedge clk);
        end
        blank_lz = 1'b0;

        // Valid held from mid-frame: one accept, then wait for the boundary.
        runCycles(6);
        digits     = 16'h5555;
        dp_mask    = 4'h2;
        load_valid = 1'b1;
        runCycles(40);
        load_valid = 1'b0;

        // Blinking on, then off again.
        blink_en = 1'b1;
        sawOff   = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (ssdAnode == 8'hFF) sawOff = 1'b1;
        end
        checkOutput("blink_dark", 16'(sawOff), 16'h1);
        blink_en = 1'b0;
        runCycles(20);

        // Non-BCD nibbles render as dashes.
        applyStimulus(16'hABCF, 4'b1010);
        runCycles(36);
        checkOutput("dash", 16'(ssdCathode), 16'h003F);

        // Reset with a load still pending: it must be discarded.
        applyStimulus(16'h9876, 4'hF);
        runCycles(2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_anode", 16'(ssdAnode), 16'h00FF);
        checkOutput("midrst_ready", 16'(load_ready), 16'h0001);
        reset = 1'b0;
        runCycles(8);
        checkOutput("postrst_cath", 16'(ssdCathode), 16'h0040);
        checkOutput("postrst_dp", 16'(ssdDp), 16'h0001);
        runCycles(20);

        // Randomised traffic including occasional resets and mode changes.
        for (int i = 0; i < 900; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            digits     = ($urandom_range(0, 2) == 0) ? 16'($urandom)
                                                     : 16'($urandom_range(0, 9) << (4 * $urandom_range(0, 3)));
            dp_mask    = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        runCycles(20);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
